// File: rtl/enc_pkg.sv
// Shared types and helpers for the sequential priority encoder.
package enc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Index width for a vector of the given size; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/encoder_prio_comb.sv
// Combinational priority encoder: index of the winning set bit plus any/multi flags.
module encoder_prio_comb
  import enc_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b0,
  localparam int W        = clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi
);

  // The last match in loop order wins, so the scan direction is the reverse of the priority.
  always_comb begin
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  assign any   = |vec;
  assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/encoder_scan_seq.sv
// Sequential priority encoder: captures a vector and emits one set-bit index per beat.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | nothing pending; in_ready=1, waiting for in_valid
//   ST_SCAN | emitting indices of pending bits, one per accepted beat
module encoder_scan_seq
  import enc_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b0,
  localparam int W        = clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_zero
);

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           zero_q, zero_d;

  logic [W-1:0]   prio_idx;
  logic           pend_any;
  logic           pend_multi;
  logic [N-1:0]   clr_mask;
  logic           scan;
  logic           beat;
  logic           capture;

  encoder_prio_comb #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio (
    .vec   (pending_q),
    .idx   (prio_idx),
    .any   (pend_any),
    .multi (pend_multi)
  );

  assign scan      = (state_q == ST_SCAN);
  assign out_valid = scan;
  assign out_idx   = scan ? prio_idx : '0;
  assign out_last  = scan & ~pend_multi;
  assign out_zero  = scan & zero_q;

  assign beat     = out_valid & out_ready;
  assign in_ready = ~scan | (beat & out_last);
  assign capture  = in_valid & in_ready;
  assign clr_mask = pend_any ? (N'(1) << prio_idx) : '0;

  // A capture on the final beat overrides the return to idle, giving bubble-free reloads.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = zero_q;
    if (beat) begin
      pending_d = pending_q & ~clr_mask;
      if (out_last) state_d = ST_IDLE;
    end
    if (capture) begin
      pending_d = in_data;
      zero_d    = (in_data == '0);
      state_d   = ST_SCAN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

endmodule

// File: tb/tb_encoder_scan_seq.sv
// Directed bench for encoder_scan_seq: N=4 LSB-first, N=4 MSB-first and N=8 instances.
module tb_encoder_scan_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic [2:0] ir, ov, ol, oz;
  logic [1:0] idx0, idx1;
  logic [2:0] idx2;
  logic [2:0] oidx [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  encoder_scan_seq #(.N(4), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir[0]),
    .in_data(in_data[3:0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_idx(idx0), .out_last(ol[0]), .out_zero(oz[0])
  );

  encoder_scan_seq #(.N(4), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir[1]),
    .in_data(in_data[3:0]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_idx(idx1), .out_last(ol[1]), .out_zero(oz[1])
  );

  encoder_scan_seq #(.N(8), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
    .out_idx(idx2), .out_last(ol[2]), .out_zero(oz[2])
  );

  assign oidx[0] = {1'b0, idx0};
  assign oidx[1] = {1'b0, idx1};
  assign oidx[2] = idx2;

  typedef struct {
    int         dut;
    logic [7:0] din;
    int         n;
    logic [31:0] seq;  // expected index of beat b in nibble b
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic run_vec(input int d, input logic [7:0] din, input int n,
                         input logic [31:0] seq, input string tag);
    int exp_zero;
    exp_zero = (din == 8'h00) ? 1 : 0;
    @(posedge clk); #1;
    in_valid[d] = 1'b1;
    in_data     = din;
    #1 chk({tag, "_cap_ready"}, int'(ir[d]), 1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_data     = ~din;
    for (int b = 0; b < n; b++) begin
      #1;
      chk({tag, "_valid"}, int'(ov[d]), 1);
      chk({tag, "_idx"}, int'(oidx[d]), int'((seq >> (4 * b)) & 32'h7));
      chk({tag, "_last"}, int'(ol[d]), (b == n - 1) ? 1 : 0);
      chk({tag, "_zero"}, int'(oz[d]), exp_zero);
      chk({tag, "_in_ready"}, int'(ir[d]), (b == n - 1) ? 1 : 0);
      @(posedge clk); #1;
    end
    #1 chk({tag, "_done_idle"}, int'(ov[d]), 0);
  endtask

  initial begin
    in_valid  = 3'b000;
    in_data   = 8'h00;
    out_ready = 1'b1;

    vecs[0]  = '{0, 8'h0A, 2, 32'h0000_0031};
    vecs[1]  = '{1, 8'h07, 3, 32'h0000_0012};
    vecs[2]  = '{0, 8'h00, 1, 32'h0000_0000};
    vecs[3]  = '{0, 8'h04, 1, 32'h0000_0002};
    vecs[4]  = '{1, 8'h0A, 2, 32'h0000_0013};
    vecs[5]  = '{0, 8'h0F, 4, 32'h0000_3210};
    vecs[6]  = '{1, 8'h0F, 4, 32'h0000_0123};
    vecs[7]  = '{2, 8'hFF, 8, 32'h7654_3210};
    vecs[8]  = '{2, 8'h80, 1, 32'h0000_0007};
    vecs[9]  = '{2, 8'h48, 2, 32'h0000_0063};
    vecs[10] = '{1, 8'h00, 1, 32'h0000_0000};

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", int'(ov[d]), 0);
      chk("rst_idx", int'(oidx[d]), 0);
      chk("rst_last", int'(ol[d]), 0);
      chk("rst_zero", int'(oz[d]), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) chk("rst_in_ready", int'(ir[d]), 1);

    for (int v = 0; v < 11; v++) begin
      run_vec(vecs[v].dut, vecs[v].din, vecs[v].n, vecs[v].seq, $sformatf("vec%0d", v));
    end

    // Backpressure: first index must hold while the consumer stalls.
    @(posedge clk); #1;
    in_valid[0] = 1'b1;
    in_data     = 8'h09;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    out_ready   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_hold_valid", int'(ov[0]), 1);
      chk("bp_hold_idx", int'(oidx[0]), 0);
      chk("bp_hold_last", int'(ol[0]), 0);
      chk("bp_hold_in_ready", int'(ir[0]), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_beat0_idx", int'(oidx[0]), 0);
    chk("bp_beat0_last", int'(ol[0]), 0);
    @(posedge clk); #1;
    chk("bp_beat1_valid", int'(ov[0]), 1);
    chk("bp_beat1_idx", int'(oidx[0]), 3);
    chk("bp_beat1_last", int'(ol[0]), 1);
    @(posedge clk); #1;
    chk("bp_idle", int'(ov[0]), 0);

    // Back-to-back: reload on the last beat without an idle cycle.
    @(posedge clk); #1;
    in_valid[0] = 1'b1;
    in_data     = 8'h04;
    @(posedge clk); #1;
    in_data = 8'h01;
    #1;
    chk("b2b_first_valid", int'(ov[0]), 1);
    chk("b2b_first_idx", int'(oidx[0]), 2);
    chk("b2b_first_last", int'(ol[0]), 1);
    chk("b2b_first_in_ready", int'(ir[0]), 1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    #1;
    chk("b2b_second_valid", int'(ov[0]), 1);
    chk("b2b_second_idx", int'(oidx[0]), 0);
    chk("b2b_second_last", int'(ol[0]), 1);
    @(posedge clk); #1;
    chk("b2b_idle", int'(ov[0]), 0);

    // Reset mid-scan on the N=8 instance.
    @(posedge clk); #1;
    in_valid[2] = 1'b1;
    in_data     = 8'hFF;
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      #1 chk("mid_idx", int'(oidx[2]), b);
      @(posedge clk); #1;
    end
    chk("mid_before_rst_idx", int'(oidx[2]), 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(ov[2]), 0);
    chk("mid_rst_idx", int'(oidx[2]), 0);
    chk("mid_rst_last", int'(ol[2]), 0);
    chk("mid_rst_zero", int'(oz[2]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", int'(ir[2]), 1);
    chk("mid_rel_valid", int'(ov[2]), 0);
    run_vec(2, 8'h80, 1, 32'h0000_0007, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
